vga_sync_rx: RTL and testbench

- Receiving end of the VGA link: takes HSync/VSync/RGB as produced by the `vga` block and recovers pixel column, row and colour.
- Checks the stream against the 640x480@60 timing and reports lock and timing errors.
- Used in-fabric for self-test loopback, for frame-accurate event capture, and as the monitor for simulation benches.
- Runs on the same pixel clock as the transmitter (25 MHz Go Board clock).

---
 rtl/vga_sync_rx.sv | 197 +++++++++++++++++++
 tb/tb_vga_sync_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// VGA link receiver: recovers column, row and colour from HSync/VSync/RGB and
// checks the stream against the configured raster timing, reporting lock and errors.
module vga_sync_rx #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_HSync,
    input  logic       i_VSync,
    input  logic [8:0] i_Pixel,
    output logic [9:0] o_Col,
    output logic [9:0] o_Row,
    output logic       o_Active,
    output logic [8:0] o_Pixel,
    output logic       o_Frame_Start,
    output logic       o_Locked,
    output logic       o_Err,
    output logic [7:0] o_Frame_Count
);

    localparam logic       SYNC_ASSERT = (SYNC_POL != 0);
    localparam logic [9:0] H_START     = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END       = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_START     = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END       = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] CNT_MAX     = 10'h3FF;
    localparam logic [2:0] GOOD_TARGET = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // [0],[1] are the two input stages; [2] is the edge-detect reference.
    logic [2:0] hs_pipe;
    logic [2:0] vs_pipe;
    logic [8:0] pix_s1;
    logic [8:0] pix_s2;

    logic       h_edge;
    logic       v_edge;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_now;
    logic [9:0] v_now;
    logic       vsync_pending;
    logic       line_bad;
    logic       line_fail;
    logic       frame_ok;

    state_t     state;
    state_t     state_next;
    logic [2:0] good;
    logic [2:0] good_next;
    logic       err_next;
    logic       frame_start_next;
    logic       active_now;

    assign h_edge = (hs_pipe[1] == SYNC_ASSERT) && (hs_pipe[2] != SYNC_ASSERT);
    assign v_edge = (vs_pipe[1] == SYNC_ASSERT) && (vs_pipe[2] != SYNC_ASSERT);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            hs_pipe <= {3{~SYNC_ASSERT}};
            vs_pipe <= {3{~SYNC_ASSERT}};
            pix_s1  <= '0;
            pix_s2  <= '0;
        end else begin
            hs_pipe <= {hs_pipe[1:0], i_HSync};
            vs_pipe <= {vs_pipe[1:0], i_VSync};
            pix_s1  <= i_Pixel;
            pix_s2  <= pix_s1;
        end
    end

    // h_now/v_now are the coordinates of the sample now in stage 2, so the
    // counters, the window and pix_s2 stay aligned without extra delay.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        h_now = (h_cnt == CNT_MAX) ? h_cnt : h_cnt + 10'd1;
        v_now = v_cnt;
        if (h_edge) begin
            h_now = '0;
            if (vsync_pending || v_edge) begin
                v_now = '0;
            end else if (v_cnt != CNT_MAX) begin
                v_now = v_cnt + 10'd1;
            end
        end
    end

    assign line_fail = h_edge && (h_cnt != H_LAST);
    // A line closing on the same edge as vsync belongs to the frame being judged.
    assign frame_ok  = (v_cnt == V_LAST) && !line_bad && !line_fail;

    always_comb begin
        state_next       = state;
        good_next        = good;
        err_next         = 1'b0;
        frame_start_next = 1'b0;
        case (state)
            SEARCH: begin
                if (v_edge) begin
                    state_next = ACQUIRE;
                    good_next  = '0;
                end
            end
            ACQUIRE: begin
                if (v_edge) begin
                    if (!frame_ok) begin
                        good_next = '0;
                    end else if (3'(good + 3'd1) == GOOD_TARGET) begin
                        state_next       = LOCKED;
                        good_next        = '0;
                        frame_start_next = 1'b1;
                    end else begin
                        good_next = good + 3'd1;
                    end
                end
            end
            LOCKED: begin
                if (line_fail || (v_edge && !frame_ok)) begin
                    err_next   = 1'b1;
                    state_next = ACQUIRE;
                    good_next  = '0;
                end else if (v_edge) begin
                    frame_start_next = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
                good_next  = '0;
            end
        endcase
    end

    assign active_now = (state == LOCKED)
                     && (h_now >= H_START) && (h_now < H_END)
                     && (v_now >= V_START) && (v_now < V_END);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            vsync_pending <= 1'b0;
            line_bad      <= 1'b0;
            state         <= SEARCH;
            good          <= '0;
        end else begin
            h_cnt         <= h_now;
            v_cnt         <= v_now;
            vsync_pending <= h_edge ? 1'b0 : (v_edge ? 1'b1 : vsync_pending);
            line_bad      <= v_edge ? 1'b0 : (line_bad || line_fail);
            state         <= state_next;
            good          <= good_next;
        end
    end

    // o_Locked follows the current state, so it drops one cycle after o_Err.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Col         <= '0;
            o_Row         <= '0;
            o_Active      <= 1'b0;
            o_Pixel       <= '0;
            o_Frame_Start <= 1'b0;
            o_Locked      <= 1'b0;
            o_Err         <= 1'b0;
            o_Frame_Count <= '0;
        end else begin
            o_Active      <= active_now;
            o_Col         <= active_now ? h_now - H_START : '0;
            o_Row         <= active_now ? v_now - V_START : '0;
            o_Pixel       <= active_now ? pix_s2 : '0;
            o_Frame_Start <= frame_start_next;
            o_Locked      <= (state == LOCKED);
            o_Err         <= err_next;
            if (frame_start_next) begin
                o_Frame_Count <= o_Frame_Count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx: drives a raster with scaled-down timing so a
// full run stays short, and checks lock, alignment, error and reset behaviour.
module tb_vga_sync_rx;

    localparam int H_TOTAL  = 40;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 6;
    localparam int H_ACTIVE = 24;
    localparam int V_TOTAL  = 20;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int V_ACTIVE = 12;
    localparam int H_START  = H_SYNC + H_BP;
    localparam int V_START  = V_SYNC + V_BP;
    localparam int ACTIVE_PER_FRAME = H_ACTIVE * V_ACTIVE;
    localparam int FS_TO_FIRST_ACTIVE = V_START * H_TOTAL + H_START;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [8:0] pixel = '0;

    logic [9:0] col;
    logic [9:0] row;
    logic       active;
    logic [8:0] pix_out;
    logic       frame_start;
    logic       locked;
    logic       err;
    logic [7:0] frame_count;

    int errors = 0;
    int checks = 0;
    int edges = 0;

    int act_cnt = 0;
    int last_act = -1;
    int err_cnt = 0;
    int err_edge = 0;
    int fall_edge = 0;
    int fs_edge = 0;
    int mon_first_edge = 0;
    int drv_first_edge = 0;
    logic prev_locked = 1'b0;
    logic prev_active = 1'b0;

    vga_sync_rx #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE),
        .SYNC_POL(0), .LOCK_FRAMES(2)
    ) dut (
        .i_Clk(clk),
        .i_Reset_n(rst_n),
        .i_HSync(hsync),
        .i_VSync(vsync),
        .i_Pixel(pixel),
        .o_Col(col),
        .o_Row(row),
        .o_Active(active),
        .o_Pixel(pix_out),
        .o_Frame_Start(frame_start),
        .o_Locked(locked),
        .o_Err(err),
        .o_Frame_Count(frame_count)
    );

    always #10 clk = ~clk;
    always @(posedge clk) edges++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] exp_pix(input int c, input int r);
        logic [31:0] cv;
        logic [31:0] rv;
        cv = c;
        rv = r;
        return {cv[2:0], rv[2:0], 3'b101};
    endfunction

    // One link cycle at raster position (v, h), driven on the falling edge.
    task automatic drive(input int v, input int h);
        @(negedge clk);
        hsync = (h < H_SYNC) ? 1'b0 : 1'b1;
        vsync = (v < V_SYNC) ? 1'b0 : 1'b1;
        if (h >= H_START && h < H_START + H_ACTIVE && v >= V_START && v < V_START + V_ACTIVE) begin
            pixel = exp_pix(h - H_START, v - V_START);
            if (h == H_START && v == V_START) drv_first_edge = edges;
        end else begin
            pixel = '0;
        end
    endtask

    task automatic drive_frame(input int n_lines, input int short_line);
        for (int v = 0; v < n_lines; v++) begin
            for (int h = 0; h < ((v == short_line) ? H_TOTAL - 1 : H_TOTAL); h++) begin
                drive(v, h);
            end
        end
    endtask

    // Output monitor, sampling mid-cycle after each rising edge.
    always @(posedge clk) begin
        #5;
        if (active) act_cnt++;
        if (frame_start) begin
            last_act = act_cnt;
            act_cnt  = 0;
            fs_edge  = edges;
            check("idle_outputs_at_frame_start", {active, col, row, pix_out}, '0);
        end
        if (err) begin
            err_cnt++;
            err_edge = edges;
        end
        if (prev_locked && !locked && fall_edge == 0) fall_edge = edges;
        if (active && !prev_active && col == 10'd0 && row == 10'd0) mon_first_edge = edges;
        if (active && col == 10'd0 && row == 10'd0)
            check("pixel_at_0_0", pix_out, exp_pix(0, 0));
        if (active && col == 10'd5 && row == 10'd3)
            check("pixel_at_5_3", pix_out, exp_pix(5, 3));
        if (active && col == 10'(H_ACTIVE - 1) && row == 10'(V_ACTIVE - 1))
            check("pixel_at_corner", pix_out, exp_pix(H_ACTIVE - 1, V_ACTIVE - 1));
        prev_locked = locked;
        prev_active = active;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {col, row, active, pix_out, frame_start, locked, err, frame_count}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("outputs_after_release", {locked, frame_count, err}, '0);

        // Clean lock, alignment and simultaneous sync edges.
        drive_frame(V_TOTAL, -1);
        check("locked_after_f1", locked, 0);
        drive_frame(V_TOTAL, -1);
        check("locked_after_f2", locked, 0);
        drive_frame(V_TOTAL, -1);
        check("locked_after_f3", locked, 1);
        check("count_after_f3", frame_count, 1);
        drive_frame(V_TOTAL, -1);
        check("count_after_f4", frame_count, 2);
        check("no_err_clean", err_cnt, 0);
        check("active_cycles_per_frame", last_act, ACTIVE_PER_FRAME);
        check("pixel_latency", mon_first_edge - drv_first_edge, 3);
        check("first_active_after_vsync", mon_first_edge - fs_edge, FS_TO_FIRST_ACTIVE);

        // One short line while locked.
        drive_frame(V_TOTAL, 8);
        check("err_pulses_short_line", err_cnt, 1);
        check("lock_drop_next_cycle", fall_edge - err_edge, 1);
        check("locked_after_short", locked, 0);
        check("count_retained", frame_count, 3);
        drive_frame(V_TOTAL, -1);
        drive_frame(V_TOTAL, -1);
        check("locked_after_one_clean", locked, 0);
        drive_frame(V_TOTAL, -1);
        check("relocked", locked, 1);
        check("count_after_relock", frame_count, 4);
        check("err_count_stable", err_cnt, 1);

        // Async reset in the middle of an active line.
        for (int v = 0; v < 10; v++) begin
            for (int h = 0; h < H_TOTAL; h++) drive(v, h);
        end
        for (int h = 0; h <= 20; h++) drive(10, h);
        check("active_before_reset", active, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {col, row, active, pix_out, frame_start, locked, err, frame_count}, '0);
        @(negedge clk);
        hsync = 1'b1;
        vsync = 1'b1;
        pixel = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("count_after_reset", frame_count, 0);

        // Relock from SEARCH, with a short frame while ACQUIRE has good=1.
        drive_frame(V_TOTAL, -1);
        check("locked_after_fa", locked, 0);
        drive_frame(V_TOTAL - 1, -1);
        check("locked_after_short_frame", locked, 0);
        drive_frame(V_TOTAL, -1);
        check("locked_after_fc", locked, 0);
        drive_frame(V_TOTAL, -1);
        check("locked_after_fd", locked, 0);
        drive_frame(V_TOTAL, -1);
        check("locked_after_fe", locked, 1);
        check("count_after_fe", frame_count, 1);
        check("no_err_in_acquire", err_cnt, 1);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
